// File: rtl/data_mem_responder.sv
// Single-port data RAM responder: valid/ready request, fixed-latency one-cycle response.
// Optional macro DMEM_CYCLE_COUNTER_EN maps a free-running cycle counter at 0xFFFF_FFF0.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam int unsigned WAIT_M1 = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
  localparam bit          NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        write_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_unsigned;
  logic        cur_write;

  logic [AW-1:0] idx;
  logic [31:0]   word_rd;
  logic [31:0]   shifted;
  logic [31:0]   lane_val;
  logic [31:0]   rdata_c;
  logic [31:0]   wlane;
  logic [3:0]    be;
  logic          oor;
  logic          err;
  logic          is_mmio;
  logic          mem_we;

`ifdef DMEM_CYCLE_COUNTER_EN
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;
  logic [31:0] cycle_cnt;
  logic [31:0] cnt_snap;

  // Free-running cycle counter and its snapshot at the accepting edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'd0;
      cnt_snap  <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept) cnt_snap <= cycle_cnt;
    end
  end
`endif

  assign accept = (state == IDLE) && req_ready && req_valid;
  assign enter_resp = (accept && NO_WAIT) || ((state == WAIT) && (wait_cnt == 4'd0));

  // In IDLE the live inputs describe the operation (needed when there are no wait states).
  always_comb begin
    cur_addr     = addr_q;
    cur_wdata    = wdata_q;
    cur_size     = size_q;
    cur_unsigned = unsigned_q;
    cur_write    = write_q;
    if (state == IDLE) begin
      cur_addr     = req_addr;
      cur_wdata    = req_wdata;
      cur_size     = req_size;
      cur_unsigned = req_unsigned;
      cur_write    = req_write;
    end
  end

  // Access decode: error check, lane selection, load extension and store byte enables.
  always_comb begin
    idx      = cur_addr[AW+1:2];
    word_rd  = mem[idx];
    shifted  = word_rd >> {cur_addr[1:0], 3'b000};
    oor      = (cur_addr[31:2] >= 30'(DEPTH_WORDS));
    is_mmio  = 1'b0;
`ifdef DMEM_CYCLE_COUNTER_EN
    is_mmio  = (cur_addr == MMIO_ADDR);
`endif
    err      = 1'b0;
    be       = 4'b0000;
    wlane    = cur_wdata;
    lane_val = word_rd;
    case (cur_size)
      2'b00: begin
        err      = oor;
        be       = 4'b0001 << cur_addr[1:0];
        wlane    = {4{cur_wdata[7:0]}};
        lane_val = {{24{~cur_unsigned & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        err      = cur_addr[0] | oor;
        be       = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{cur_wdata[15:0]}};
        lane_val = {{16{~cur_unsigned & shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        err      = (cur_addr[1:0] != 2'b00) | (oor & ~is_mmio);
        be       = 4'b1111;
      end
      default: err = 1'b1;
    endcase
`ifdef DMEM_CYCLE_COUNTER_EN
    if (is_mmio) lane_val = (state == IDLE) ? cycle_cnt : cnt_snap;
`endif
    rdata_c = (err | cur_write) ? 32'd0 : lane_val;
    mem_we  = enter_resp & cur_write & ~err & ~is_mmio;
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= ~accept;
          if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            write_q    <= req_write;
            if (NO_WAIT) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_M1);
            end
          end
        end
        WAIT: begin
          req_ready <= 1'b0;
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_rdata <= rdata_c;
        resp_error <= err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 1 and 3 wait states) against a byte-array model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic [2:0]  rst_n;
  logic [2:0]  req_valid, req_write, req_unsigned;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [1:0]  req_size [3];
  logic [2:0]  req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata [3];

  int n_cmp = 0;
  int n_mis = 0;
  int unsigned cyc_cnt = 0;
  logic [7:0] mdl [3][4*DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clock(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut1 (
    .clock(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut2 (
    .clock(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_wdata(req_wdata[2]), .req_ready(req_ready[2]), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: little-endian byte array; returns expected load data / error and applies stores.
  task automatic model_access(input int d, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                              input bit uns, input logic [31:0] wd,
                              output logic [31:0] rd, output bit er);
    int nb;
    logic [63:0] val;
    er = 1'b0;
    rd = 32'd0;
    nb = 1 << sz;
    if (sz == 2'd3) er = 1'b1;
    else if ((a % nb) != 0) er = 1'b1;
    else if ((a / 4) >= DEPTH) er = 1'b1;
    if (er) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
    end else begin
      val = 64'd0;
      for (int i = 0; i < nb; i++) val = val | (64'(mdl[d][int'(a) + i]) << (8*i));
      if (!uns && val[8*nb-1]) val = val | ~((64'd1 << (8*nb)) - 64'd1);
      rd = val[31:0];
    end
  endtask

  task automatic present(input int d, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input bit uns, input logic [31:0] wd);
    req_write[d]    = wr;
    req_addr[d]     = a;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_wdata[d]    = wd;
  endtask

  // One transaction; checks latency, pulse width and idle-zero outputs. Ends at a negedge.
  task automatic do_req(input int d, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                        input bit uns, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int unsigned acc_cyc);
    int n;
    rd = 32'd0;
    er = 1'b0;
    @(negedge clk);
    present(d, wr, a, sz, uns, wd);
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      check("accept_timeout", 0, 1);
      req_valid[d] = 1'b0;
      return;
    end
    acc_cyc = cyc_cnt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!resp_valid[d]) begin
        check("idle_zero", {resp_error[d], resp_rdata[d]}, 0);
        present(d, 1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom);
      end
    end while (!resp_valid[d] && n < 40);
    rd = resp_rdata[d];
    er = resp_error[d];
    req_valid[d] = 1'b0;
    check("latency", n, ws_of(d) + 1);
    @(negedge clk);
    check("pulse_end", {resp_valid[d], resp_error[d], resp_rdata[d]}, 0);
  endtask

  task automatic do_access(input int d, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                           input bit uns, input logic [31:0] wd);
    logic [31:0] exp_rd, got_rd;
    bit exp_er, got_er;
    int unsigned c;
    model_access(d, wr, a, sz, uns, wd, exp_rd, exp_er);
    do_req(d, wr, a, sz, uns, wd, got_rd, got_er, c);
    check("rdata", got_rd, exp_rd);
    check("error", got_er, exp_er);
  endtask

  initial begin
    logic [31:0] rd1, rd2, er_rd, exp_rd;
    bit er1, er2, exp_er;
    int unsigned c1, c2;
    bit cw [12];
    logic [31:0] ca [12];
    logic [1:0] cs [12];
    bit cu [12];
    logic [31:0] cd [12];
    logic [31:0] q_rd [$];
    bit q_er [$];
    int acc, nresp;
    bit pend;

    rst_n = 3'b000;
    req_valid = 3'b000;
    for (int d = 0; d < 3; d++) present(d, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", req_ready[d], 0);
      check("rst_valid", resp_valid[d], 0);
      check("rst_rdata", resp_rdata[d], 0);
      check("rst_error", resp_error[d], 0);
    end
    rst_n = 3'b111;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check("ready_after_rst", req_ready[d], 1);

    // Fill every word so later loads have known contents.
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < DEPTH; w++) do_access(d, 1'b1, 32'(4*w), 2'd2, 1'b0, $urandom);

    // Directed store/load sequences, including the documented constants.
    do_access(1, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    do_req(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd1, er1, c1);
    check("w1_load_word", rd1, 32'hDEADBEEF);
    do_access(1, 1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080);
    do_req(1, 1'b0, 32'h13, 2'd0, 1'b0, 32'd0, rd1, er1, c1);
    check("byte_signed", rd1, 32'hFFFFFF80);
    do_req(1, 1'b0, 32'h13, 2'd0, 1'b1, 32'd0, rd1, er1, c1);
    check("byte_unsigned", rd1, 32'h00000080);
    do_req(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd1, er1, c1);
    check("word_merged", rd1, 32'h80ADBEEF);
    do_access(1, 1'b0, 32'h11, 2'd1, 1'b0, 32'd0);
    do_access(1, 1'b1, 32'h12, 2'd2, 1'b0, 32'h12345678);
    do_access(1, 1'b1, 32'h10, 2'd3, 1'b0, 32'h12345678);
    do_access(1, 1'b1, 32'(4*DEPTH), 2'd2, 1'b0, 32'h12345678);
    do_access(1, 1'b0, 32'(4*DEPTH), 2'd2, 1'b0, 32'd0);
    do_req(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd1, er1, c1);
    check("ram_unchanged", rd1, 32'h80ADBEEF);

    // Mid-operation reset abandons an uncommitted store.
    do_access(2, 1'b1, 32'h20, 2'd2, 1'b0, 32'h11223344);
    @(negedge clk);
    present(2, 1'b1, 32'h20, 2'd2, 1'b0, 32'hAABBCCDD);
    req_valid[2] = 1'b1;
    check("rst_test_ready", req_ready[2], 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n[2] = 1'b0;
    #1 check("midrst_ready", req_ready[2], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_ready_hold", req_ready[2], 0);
      check("midrst_valid", resp_valid[2], 0);
    end
    rst_n[2] = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", req_ready[2], 1);
    do_req(2, 1'b0, 32'h20, 2'd2, 1'b0, 32'd0, rd1, er1, c1);
    check("midrst_old_data", rd1, 32'h11223344);
    check("midrst_old_err", er1, 0);

    // Continuous valid with zero wait states: accept every other cycle, in order.
    for (int i = 0; i < 12; i++) begin
      cw[i] = (i % 2) == 0;
      cs[i] = 2'(i % 3);
      ca[i] = 32'($urandom_range(0, 15) * 4 + ((cs[i] == 2'd0) ? (i % 4) : (cs[i] == 2'd1) ? 2 : 0));
      cu[i] = 1'($urandom);
      cd[i] = $urandom;
    end
    for (int i = 1; i < 12; i += 2) begin
      ca[i] = ca[i-1];
      cs[i] = cs[i-1];
    end
    present(0, cw[0], ca[0], cs[0], cu[0], cd[0]);
    req_valid[0] = 1'b1;
    acc = 0;
    nresp = 0;
    pend = 1'b0;
    for (int cyc = 0; cyc < 40 && nresp < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pend) begin
        if (acc < 12) present(0, cw[acc], ca[acc], cs[acc], cu[acc], cd[acc]);
        else req_valid[0] = 1'b0;
        pend = 1'b0;
      end
      check("cont_ready", req_ready[0], (cyc % 2) == 0);
      check("cont_valid", resp_valid[0], (cyc % 2) == 1);
      if (resp_valid[0]) begin
        if (q_rd.size() == 0) begin
          check("cont_unexpected", 1, 0);
        end else begin
          check("cont_rdata", resp_rdata[0], q_rd.pop_front());
          check("cont_error", resp_error[0], q_er.pop_front());
        end
        nresp++;
      end
      if (req_ready[0] && acc < 12) begin
        model_access(0, cw[acc], ca[acc], cs[acc], cu[acc], cd[acc], exp_rd, exp_er);
        q_rd.push_back(exp_rd);
        q_er.push_back(exp_er);
        acc++;
        pend = 1'b1;
      end
    end
    req_valid[0] = 1'b0;
    check("cont_accepts", acc, 12);
    check("cont_responses", nresp, 12);

    // Randomized traffic on all three instances.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 60; k++) begin
        logic [1:0] sz;
        sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        do_access(d, 1'($urandom), 32'($urandom_range(0, 4*DEPTH + 7)), sz, 1'($urandom), $urandom);
      end
    end

    // Cycle-counter window (or its absence).
`ifdef DMEM_CYCLE_COUNTER_EN
    do_req(0, 1'b0, 32'hFFFF_FFF0, 2'd2, 1'b0, 32'd0, rd1, er1, c1);
    repeat (7) @(negedge clk);
    do_req(0, 1'b0, 32'hFFFF_FFF0, 2'd2, 1'b0, 32'd0, rd2, er2, c2);
    check("cnt_err1", er1, 0);
    check("cnt_err2", er2, 0);
    check("cnt_delta", rd2 - rd1, 32'(c2 - c1));
    do_req(0, 1'b1, 32'hFFFF_FFF0, 2'd2, 1'b0, 32'h5, er_rd, er1, c1);
    check("cnt_store_err", er1, 0);
    do_req(0, 1'b0, 32'hFFFF_FFF0, 2'd0, 1'b0, 32'd0, er_rd, er1, c1);
    check("cnt_byte_err", er1, 1);
    check("cnt_byte_rdata", er_rd, 0);
`else
    do_req(0, 1'b0, 32'hFFFF_FFF0, 2'd2, 1'b0, 32'd0, rd1, er1, c1);
    check("cnt_absent_err", er1, 1);
    check("cnt_absent_rdata", rd1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: RAM size in 32-bit words; power of two, 16..65536.
REQ-002 SHALL have parameter WAIT_STATES, default 1: extra cycles between accept and response; range 0..15.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 SHALL have port req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-010 SHALL have port req_wdata  input  32  store data; low bits are used for byte and half.
REQ-011 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-012 SHALL have port resp_valid  output  1  response is present, one-cycle pulse.
REQ-013 SHALL have port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 SHALL have port resp_error  output  1  request was rejected; qualified by resp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-016 SHALL accept a request when req_valid and req_ready are both 1 at a clock edge, and SHALL register the address, size, unsigned, write and wdata fields.
REQ-017 SHALL transition from IDLE on accept to WAIT if WAIT_STATES>0, else to RESP.
REQ-018 SHALL stay in WAIT for exactly WAIT_STATES cycles using a down-counter, then enter RESP.
REQ-019 SHALL hold resp_valid=1 for exactly the one cycle spent in RESP, then return to IDLE; back-to-back requests SHALL have a minimum spacing of WAIT_STATES+2 cycles.
REQ-020 SHALL assert resp_valid exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-021 SHALL ignore req_valid and all req_* inputs outside IDLE.
REQ-022 SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-023 SHALL flag an error for: size 11; half with addr[0]=1; word with addr[1:0]!=0; word index (addr>>2) >= DEPTH_WORDS.
REQ-024 SHALL, on error, perform no RAM write, drive resp_rdata=0 and resp_error=1.
REQ-025 SHALL commit stores on the edge entering RESP, updating only the addressed byte lanes.
REQ-026 SHALL extract the addressed lane on loads, extend it per req_unsigned to 32 bits, and hold the result in resp_rdata for the RESP cycle.
REQ-027 SHALL drive resp_rdata=0 and resp_error=0 whenever resp_valid=0.
REQ-028 SHALL return, for a load following a store to the same address, the stored data.

Reset
REQ-029 SHALL, while reset=0, force state to IDLE, the counter to 0, req_ready=0, resp_valid=0, resp_rdata=0 and resp_error=0.
REQ-030 SHALL drive req_ready=1 at the first clock edge after reset deasserts.
REQ-031 SHALL abandon an in-flight request on mid-operation reset; a store not yet committed SHALL NOT be written.
REQ-032 SHALL NOT reset RAM contents.

Configuration
REQ-033 SHALL, when macro DMEM_CYCLE_COUNTER_EN is defined, provide a free-running 32-bit cycle counter that resets to 0, increments every clock and wraps from 0xFFFF_FFFF to 0.
REQ-034 SHALL, with DMEM_CYCLE_COUNTER_EN defined, return the counter value sampled on the accept edge for a word load at 0xFFFF_FFF0, without error.
REQ-035 SHALL, with DMEM_CYCLE_COUNTER_EN defined, ignore stores to 0xFFFF_FFF0 without error; byte and half accesses there SHALL error.
REQ-036 SHALL, without DMEM_CYCLE_COUNTER_EN, treat 0xFFFF_FFF0 as out of range (error).

Verification
REQ-037 SHALL cover: WAIT_STATES=1, store word 0xDEADBEEF at 0x10, then load word at 0x10 -> resp_valid 2 cycles after each accept, rdata=0xDEADBEEF.
REQ-038 SHALL cover: store byte 0x80 at 0x13, then signed byte load at 0x13 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load at 0x10 -> 0x80ADBEEF.
REQ-039 SHALL cover: half load at 0x11, word store at 0x12, size 11, and word load at 4*DEPTH_WORDS -> resp_error=1, rdata=0, RAM unchanged.
REQ-040 SHALL cover: WAIT_STATES=3, store to 0x20, reset=0 two cycles after accept, load 0x20 after reset -> old data, req_ready=0 throughout reset.
REQ-041 SHALL cover: req_valid held high continuously, WAIT_STATES=0 -> accepts every 2nd cycle, resp_valid pulses alternate, and no request is dropped or duplicated.
REQ-042 SHALL cover: with DMEM_CYCLE_COUNTER_EN, two word loads at 0xFFFF_FFF0 N cycles apart -> difference N; without the macro -> resp_error=1.
